// File: rtl/p_run_controller.sv
// Run/bring-up sequencer for the pipelined core: holds reset, pulses load_pc,
// runs until a halt address, a stable PC or the cycle budget, then freezes the core.
module p_run_controller #(
    parameter int PC_W          = 32,
    parameter int CNT_W         = 32,
    parameter int RST_CYCLES    = 1,
    parameter int LOAD_CYCLES   = 1,
    parameter int MAX_CYCLES    = 500,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             halt_pc_en,
    input  logic [PC_W-1:0]  halt_pc,
    output logic             core_reset,
    output logic             load_pc,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [PC_W-1:0]  last_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET_HOLD,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [31:0]      RST_LAST   = 32'(RST_CYCLES - 1);
    localparam logic [31:0]      LOAD_LAST  = 32'(LOAD_CYCLES - 1);
    localparam logic [31:0]      STABLE_LIM = 32'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_CYCLES);

    state_t            state, state_nxt;
    logic [31:0]       phase, phase_nxt;
    logic [31:0]       stable, stable_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [PC_W-1:0]   last_pc_nxt;
    logic              done_nxt, timeout_nxt;
    logic              core_reset_nxt, load_pc_nxt, running_nxt;
    logic              halt_hit, stable_hit, budget_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            phase       <= '0;
            stable      <= '0;
            cycle_count <= '0;
            last_pc     <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            core_reset  <= 1'b1;
            load_pc     <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            stable      <= stable_nxt;
            cycle_count <= count_nxt;
            last_pc     <= last_pc_nxt;
            done        <= done_nxt;
            timeout     <= timeout_nxt;
            core_reset  <= core_reset_nxt;
            load_pc     <= load_pc_nxt;
            running     <= running_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        stable_nxt  = stable;
        count_nxt   = cycle_count;
        last_pc_nxt = last_pc;
        done_nxt    = done;
        timeout_nxt = timeout;
        halt_hit    = 1'b0;
        stable_hit  = 1'b0;
        budget_hit  = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt   = S_RESET_HOLD;
                    phase_nxt   = '0;
                    stable_nxt  = '0;
                    count_nxt   = '0;
                    last_pc_nxt = '0;
                    done_nxt    = 1'b0;
                    timeout_nxt = 1'b0;
                end
            end
            S_RESET_HOLD: begin
                if (phase == RST_LAST) begin
                    state_nxt = S_LOAD;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase + 32'd1;
                end
            end
            S_LOAD: begin
                if (phase == LOAD_LAST) begin
                    state_nxt  = S_RUN;
                    phase_nxt  = '0;
                    stable_nxt = '0;
                end else begin
                    phase_nxt = phase + 32'd1;
                end
            end
            S_RUN: begin
                count_nxt   = cycle_count + CNT_W'(1);
                last_pc_nxt = pc_in;
                // cycle_count is still zero on the first RUN edge, so last_pc is not yet valid
                if (cycle_count == '0) begin
                    stable_nxt = '0;
                end else if (pc_in == last_pc) begin
                    stable_nxt = stable + 32'd1;
                end else begin
                    stable_nxt = '0;
                end
                halt_hit   = halt_pc_en && (pc_in == halt_pc);
                stable_hit = (stable_nxt >= STABLE_LIM);
                budget_hit = (count_nxt >= CNT_MAX);
                if (halt_hit || stable_hit || budget_hit) begin
                    state_nxt   = S_DONE;
                    done_nxt    = 1'b1;
                    timeout_nxt = budget_hit && !halt_hit && !stable_hit;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        core_reset_nxt = !((state_nxt == S_LOAD) || (state_nxt == S_RUN));
        load_pc_nxt    = (state_nxt == S_LOAD);
        running_nxt    = (state_nxt == S_RUN);
    end

endmodule

// File: doc/p_run_controller.md
Name: p_run_controller

Overview:
- Parametrised run/bring-up sequencer for the pipelined MIPS core (p_processor).
- Replaces the hand-timed reset / load_pc / fixed-delay pattern with a start-triggered state machine.
- Holds the core in reset, pulses load_pc, then runs the core until a halt condition or a cycle budget is reached.
- Reports done/timeout, the cycle count and the final PC. It sits between the test harness or top level and the core's reset/load_pc pins, and watches the core's pc_out.

Parameters:
- PC_W, 32, width of the observed PC.
- CNT_W, 32, width of cycle_count.
- RST_CYCLES, 1, cycles core_reset is held after start; must be >= 1.
- LOAD_CYCLES, 1, cycles load_pc is held high; must be >= 1.
- MAX_CYCLES, 500, RUN-cycle budget before timeout; must be >= 1 and < 2^CNT_W.
- STABLE_CYCLES, 4, consecutive unchanged-PC RUN cycles that count as a halt; must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset of this block.
- start  in  1  single-cycle request to begin a run; sampled in IDLE and DONE only.
- pc_in  in  PC_W  the core's pc_out.
- halt_pc_en  in  1  enables the explicit halt-address check.
- halt_pc  in  PC_W  halt address; reaching it ends the run.
- core_reset  out  1  active-high reset driven to the core.
- load_pc  out  1  driven to the core's load_pc.
- running  out  1  high while in RUN.
- done  out  1  sticky; the run has ended.
- timeout  out  1  sticky; the run ended on the cycle budget.
- cycle_count  out  CNT_W  number of RUN cycles of the current or last run.
- last_pc  out  PC_W  PC registered on the most recent RUN cycle.

Behaviour:
- Reset
  - Async reset: reset=0 forces state IDLE immediately, without waiting for a clock edge.
  - Reset values: core_reset=1, load_pc=0, running=0, done=0, timeout=0, cycle_count=0, last_pc=0; internal phase and stable counters cleared.
  - Reset low mid-run aborts the run with no other side effects.
- Outputs are registered (Moore), decoded from state and counters. If start is sampled at edge k, the new state is visible after edge k.
- States:
  - IDLE: core_reset=1. start=1 -> RESET_HOLD; cycle_count, last_pc, done and timeout are cleared on that edge.
  - RESET_HOLD: core_reset=1, load_pc=0 for exactly RST_CYCLES cycles, then -> LOAD.
  - LOAD: core_reset=0, load_pc=1 for exactly LOAD_CYCLES cycles, then -> RUN. core_reset falls on the same edge that load_pc rises.
  - RUN: core_reset=0, load_pc=0, running=1.
  - DONE: core_reset=1 (core frozen), running=0, done=1; cycle_count and last_pc are held. start=1 -> RESET_HOLD, clearing as in IDLE.
- start in RESET_HOLD, LOAD or RUN is ignored.
- RUN cycle rules, evaluated each RUN edge:
  - cycle_count increments by 1, wrap-free because MAX_CYCLES < 2^CNT_W.
  - last_pc <= pc_in.
  - stable_cnt increments when pc_in == last_pc, otherwise clears to 0. On the first RUN cycle the compare is suppressed (stable_cnt=0).
- RUN exit conditions, using the post-increment values:
  - (a) halt_pc_en && pc_in == halt_pc;
  - (b) stable_cnt reaches STABLE_CYCLES;
  - (c) cycle_count reaches MAX_CYCLES.
  - Any of these -> DONE on that edge, done=1.
  - timeout=1 only if (c) holds and neither (a) nor (b) holds on the same cycle; a halt takes priority.
- halt_pc_en and halt_pc are sampled every RUN cycle and may change during a run.

Test Plan:
- Startup timing, defaults:
  - Stimulus: reset low 2 cycles, release, start pulse at edge k.
  - Response: core_reset=1 through edge k+1. At edge k+1, core_reset=0 and load_pc=1 for 1 cycle. running=1 from edge k+2.
- Stable-PC halt:
  - Stimulus: pc_in=0,4,8,... stepping by 4 per RUN cycle, stopping at 0x40 (reached on RUN cycle 17), then held.
  - Response: done=1 after RUN cycle 21, timeout=0, cycle_count=21, last_pc=0x40, core_reset=1.
- Timeout:
  - Stimulus: pc_in increments every cycle with no halt.
  - Response: done=1, timeout=1, cycle_count=500 exactly, running=0.
- Halt address:
  - Stimulus: halt_pc_en=1, halt_pc=0x20, pc stepping by 4 from 0.
  - Response: exit on RUN cycle 9, cycle_count=9, last_pc=0x20, timeout=0.
- Async reset mid-run:
  - Stimulus: drive reset low between clock edges during RUN.
  - Response: all outputs take their reset values immediately, before the next edge.
- Restart and ignore:
  - Stimulus: start during RUN; later, start while in DONE.
  - Response: start during RUN has no effect. start in DONE clears done, timeout and cycle_count, re-enters RESET_HOLD, and the second run matches scenario 2.
- Override with RST_CYCLES=3, LOAD_CYCLES=2:
  - Response: core_reset high for exactly 3 cycles after the start edge, then load_pc high for exactly 2 cycles.
